// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// A prescaler steps a 2-bit slot through the four nibbles of a held 16-bit value.
// The first BLANK_CYCLES of every slot keep all anodes off so the previous digit does not ghost.
// All outputs are registered and trail cnt/slot by one cycle.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seg_scan_mux #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        dp,
    output logic        scan_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    // The scan state is the slot index itself: S0..S3 select digit 0..3.
    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} slot_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            slot_q, slot_d;
    logic [15:0]      held_value_q, held_value_d;
    logic [3:0]       held_dp_q, held_dp_d;
    logic [15:0]      shown_value_q, shown_value_d;
    logic [3:0]       shown_dp_q, shown_dp_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       digit_q, digit_d;
    logic             dp_q, dp_d;
    logic             scan_tick_q, scan_tick_d;

    logic wrap;
    logic lz_blank;
    logic an_active;

    // Prescaler and scan state machine: advance one slot per cnt wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = cnt_q + CNT_W'(1);
        slot_d = slot_q;
        if (wrap) begin
            cnt_d = '0;
            case (slot_q)
                S0:      slot_d = S1;
                S1:      slot_d = S2;
                S2:      slot_d = S3;
                default: slot_d = S0;
            endcase
        end
    end

    // Holding registers take new data on load; the shown copy is refreshed only at slot entry,
    // so a load on the wrap edge reaches the display one slot later.
    always_comb begin
        held_value_d  = load ? value : held_value_q;
        held_dp_d     = load ? dp_in : held_dp_q;
        shown_value_d = wrap ? held_value_q : shown_value_q;
        shown_dp_d    = wrap ? held_dp_q    : shown_dp_q;
    end

    // Output decode from cnt/slot: blanking gap, per-digit enable and optional leading-zero blank.
    always_comb begin
        lz_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        case (slot_q)
            S3:      lz_blank = (shown_value_q[15:12] == 4'h0);
            S2:      lz_blank = (shown_value_q[15:8]  == 8'h00);
            S1:      lz_blank = (shown_value_q[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`endif
        an_active   = (cnt_q >= BLANK_LIM) && digit_en[slot_q] && !lz_blank;
        an_d        = an_active ? ~(4'b0001 << slot_q) : 4'b1111;
        dp_d        = an_active ? ~shown_dp_q[slot_q] : 1'b1;
        // The decoder input stays on the slot nibble through blanking.
        digit_d     = shown_value_q[{slot_q, 2'b00} +: 4];
        scan_tick_d = wrap;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cnt_q         <= '0;
            slot_q        <= S0;
            held_value_q  <= '0;
            held_dp_q     <= '0;
            shown_value_q <= '0;
            shown_dp_q    <= '0;
            an_q          <= 4'b1111;
            digit_q       <= 4'h0;
            dp_q          <= 1'b1;
            scan_tick_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            held_value_q  <= held_value_d;
            held_dp_q     <= held_dp_d;
            shown_value_q <= shown_value_d;
            shown_dp_q    <= shown_dp_d;
            an_q          <= an_d;
            digit_q       <= digit_d;
            dp_q          <= dp_d;
            scan_tick_q   <= scan_tick_d;
        end
    end

    assign an        = an_q;
    assign digit     = digit_q;
    assign dp        = dp_q;
    assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
// Stimulus pushes the expected outputs of each output window (8 cycles, aligned so that
// entry 0 is the first blank cycle of a slot) into a queue; the monitor pops one entry per
// falling edge and compares. Build with +define+SEG_LEADING_ZERO_BLANK_EN for the blanking variant.
module tb_seg_scan_mux;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] digit;
        logic       dp;
        logic       tick;
    } exp_t;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dp;
    logic        scan_tick;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle_no = 0;

    seg_scan_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
        .digit_en(digit_en), .an(an), .digit(digit), .dp(dp), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @entry %0d: got %h expected %h", name, cycle_no, act, exp);
        end
    endtask

    // Monitor: compare one expected entry per falling edge while entries are pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an", {12'h0, an}, {12'h0, e.an});
                check("digit", {12'h0, digit}, {12'h0, e.digit});
                check("dp", {15'h0, dp}, {15'h0, e.dp});
                check("scan_tick", {15'h0, scan_tick}, {15'h0, e.tick});
                cycle_no++;
            end
        end
    end

    // One output window of a slot. Entry i reflects cnt=i: entries 0,1 blank, 2..7 active,
    // scan_tick high on entry 7. Optional load at edge ld_at, optional reset at edge rst_at.
    task automatic run_window(input logic [3:0] en, input logic [3:0] an_act, input logic [3:0] dig,
                              input logic dp_act, input int ld_at, input logic [15:0] ld_val,
                              input logic [3:0] ld_dp, input int rst_at);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        digit_en = en;
        n = (rst_at > 0) ? rst_at + 1 : 8;
        for (int i = 0; i < n; i++) begin
            if (rst_at > 0 && i == rst_at) begin
                e = '{an: 4'hF, digit: 4'h0, dp: 1'b1, tick: 1'b0};
            end else begin
                e.an    = (i < 2) ? 4'hF : an_act;
                e.dp    = (i < 2) ? 1'b1 : dp_act;
                e.digit = dig;
                e.tick  = (i == 7);
            end
            exp_q.push_back(e);
        end
        for (int i = 0; i < n - 1; i++) begin
            if (i == ld_at - 1) begin
                load = 1'b1; value = ld_val; dp_in = ld_dp;
            end
            if (i == ld_at) load = 1'b0;
            if (i == rst_at - 1) reset = 1'b1;
            @(posedge clk); #1;
        end
        load  = 1'b0;
        reset = 1'b0;
    endtask

    function automatic logic [3:0] lzb(input logic [3:0] act);
        return LZ ? 4'hF : act;
    endfunction

    // Stimulus.
    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        e = '{an: 4'hF, digit: 4'h0, dp: 1'b1, tick: 1'b0};
        exp_q.push_back(e);

        // Basic scan of 12AB; the first slot after reset still shows the cleared value.
        run_window(4'hF, 4'b1110, 4'h0, 1'b1, 3, 16'h12AB, 4'h0, -1);
        run_window(4'hF, 4'b1101, 4'hA, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1011, 4'h2, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b0111, 4'h1, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1110, 4'hB, 1'b1, -1, 16'h0, 4'h0, -1);
        // Mid-slot load of 00FF: slot 1 keeps A, shown from slot 2 onward.
        run_window(4'hF, 4'b1101, 4'hA, 1'b1, 4, 16'h00FF, 4'h0, -1);
        run_window(4'hF, lzb(4'b1011), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, lzb(4'b0111), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1110, 4'hF, 1'b1, 3, 16'h4321, 4'h0, -1);
        // digit_en=0101: slots 1 and 3 dark, digit keeps cycling.
        run_window(4'b0101, 4'hF, 4'h2, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'b0101, 4'b1011, 4'h3, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'b0101, 4'hF, 4'h4, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1110, 4'h1, 1'b1, 3, 16'h0000, 4'b0010, -1);
        // Decimal point on digit 1 only, active cycles only.
        run_window(4'hF, lzb(4'b1101), 4'h0, LZ ? 1'b1 : 1'b0, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, lzb(4'b1011), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, lzb(4'b0111), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1110, 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, lzb(4'b1101), 4'h0, LZ ? 1'b1 : 1'b0, -1, 16'h0, 4'h0, -1);
        // Reset at slot 2, cnt 5, after a pending load of 5555/dp F that must be discarded.
        run_window(4'hF, lzb(4'b1011), 4'h0, 1'b1, 2, 16'h5555, 4'hF, 5);
        run_window(4'hF, 4'b1110, 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, lzb(4'b1101), 4'h0, 1'b1, 3, 16'h0070, 4'h0, -1);
        // Leading-zero behaviour with 0070, then 0000.
        run_window(4'hF, lzb(4'b1011), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, lzb(4'b0111), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1110, 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1101, 4'h7, 1'b1, 3, 16'h0000, 4'h0, -1);
        run_window(4'hF, lzb(4'b1011), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, lzb(4'b0111), 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);
        run_window(4'hF, 4'b1110, 4'h0, 1'b1, -1, 16'h0, 4'h0, -1);

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed scanner for the 4-digit common-anode 7-segment display.
- Holds a 16-bit hex value and steps through its four nibbles, one per refresh slot.
- Drives the active-low anode lines, the decimal point, and a 4-bit digit code to the downstream hex-to-segment decoder.
- Inserts a short anode-off blanking gap at each digit change to suppress ghosting.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz clock gives 1 kHz per digit). Legal range 2..2^20.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off. Must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  16  hex value to display; nibble k goes to digit k (digit 0 is rightmost).
- load  input  1  when high, value and dp_in are captured into the holding registers.
- dp_in  input  4  decimal point request per digit, active-high.
- digit_en  input  4  per-digit enable; 0 forces that anode off.
- an  output  4  anode drive, active-low, one-hot-low or all ones.
- digit  output  4  nibble for the current slot, fed to the segment decoder.
- dp  output  1  decimal point, active-low.
- scan_tick  output  1  one-cycle pulse on each slot advance.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: cnt=0, slot=0, held_value=0, held_dp=0, an=4'b1111, digit=4'h0, dp=1, scan_tick=0.
- Reset mid-scan: takes effect on the next edge, with the same values as above.
- Prescaler: cnt counts 0..REFRESH_DIV-1, then wraps to 0. On the wrap edge, slot advances 0→1→2→3→0 (2-bit wrap) and scan_tick=1 for that one cycle only.
- Holding registers:
  - load=1 captures value and dp_in on that edge.
  - digit/dp sample the held data only at slot entry: the first cycle after reset, and each wrap.
  - A load mid-slot therefore shows from the next slot onward. No partial-slot update.
  - load coinciding with a wrap: the new data is not used for the slot being entered. It is first shown in the following slot.
- Output registers: an, digit and dp are registered from cnt/slot, so they lag cnt by one cycle. No combinational path from inputs to outputs.
- Anode decode (per cycle):
  - an=4'b1111 if cnt<BLANK_CYCLES, or digit_en[slot]=0, or the digit is blanked by the optional feature.
  - Otherwise an=~(4'b0001<<slot).
- Decimal point: dp=~held_dp[slot] when the anode is active, else dp=1.
- Digit value: digit=held_value[4*slot+:4] for the whole slot. It is not zeroed during blanking; the decoder input stays stable.
- Digit order: digit 0 (an[0]) is the rightmost display digit.
- digit_en is sampled live every cycle, not held.
- Scan state machine: the four states are S0..S3 (= slot). The only transition is Sk→S(k+1 mod 4) on the cnt wrap. Reset returns to S0.
- Widths: cnt is ceil(log2(REFRESH_DIV)) bits. Compare unsigned; no overflow beyond REFRESH_DIV-1.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k=3,2,1) is blanked (an bit held high, dp=1) when held_value nibbles 3 down to k are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - digit still outputs the nibble.
- Undefined: all enabled digits are shown, including leading zeros. The logic is absent from the netlist.

Test Plan:
1. REFRESH_DIV=8, BLANK_CYCLES=2; reset, then load value=16'h12AB, digit_en=4'hF, dp_in=0 -> per slot: an=1111 for 2 cycles, then active for 6 cycles; slot sequence an=1110/digit=B, 1101/A, 1011/2, 0111/1, repeating. scan_tick pulses exactly every 8 cycles. dp=1 throughout.
2. Same setup; load 16'h00FF on cnt=4 of slot 1 -> slot 1 keeps digit=A to its end; slot 2 shows 0; the next slot 0 shows F.
3. digit_en=4'b0101, value=16'h4321 -> an is never 1101 or 0111. Slots 1 and 3 stay 1111 for all 8 cycles, but digit still cycles 1,2,3,4. Slot timing is unchanged.
4. dp_in=4'b0010 loaded with value 16'h0000 -> dp=0 only during the 6 active cycles of slot 1; dp=1 during blanking and other slots.
5. Assert reset for 1 cycle at slot 2, cnt=5 -> next cycle an=1111, digit=0, scan_tick=0. Scan restarts at slot 0 with cnt=0; held value is cleared to 0.
6. With SEG_LEADING_ZERO_BLANK_EN: value=16'h0070 -> slots 3 and 2 stay an=1111; slot 1 shows 7; slot 0 shows 0. value=16'h0000 -> only slot 0 is active, showing 0. Without the macro -> all four anodes activate.
